// File: rtl/storage_arbiter.sv
// Two-port round-robin arbiter serialising instruction-fetch and load/store
// accesses onto the single storage controller, with a response timeout.
module storage_arbiter #(
    parameter int MEM_W          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_mode,
    input  logic               p0_req,
    input  logic               p0_we,
    input  logic [31:0]        p0_addr,
    input  logic [MEM_W-1:0]   p0_wdata,
    input  logic [MEM_W/8-1:0] p0_be,
    output logic               p0_gnt,
    output logic               p0_rvalid,
    output logic [MEM_W-1:0]   p0_rdata,
    output logic               p0_err,
    input  logic               p1_req,
    input  logic               p1_we,
    input  logic [31:0]        p1_addr,
    input  logic [MEM_W-1:0]   p1_wdata,
    input  logic [MEM_W/8-1:0] p1_be,
    output logic               p1_gnt,
    output logic               p1_rvalid,
    output logic [MEM_W-1:0]   p1_rdata,
    output logic               p1_err,
    output logic               memory_access,
    output logic               memory_is_writing,
    output logic [31:0]        addr,
    output logic [MEM_W-1:0]   d_in,
    output logic [MEM_W/8-1:0] mem_be,
    input  logic [MEM_W-1:0]   mem_d_out,
    input  logic               mem_done,
    output logic               busy
);

    localparam int BE_W  = MEM_W / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;
    logic               win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [MEM_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               acc_q, acc_d;
    logic               rv0_q, rv0_d, rv1_q, rv1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic [MEM_W-1:0]   rd0_q, rd0_d, rd1_q, rd1_d;
    logic               busy_q, busy_d;
    logic               pick;
    logic               timeout;

    // On a tie the port that did not win last time goes next.
    assign pick    = (p0_req && p1_req) ? ~last_q : p1_req;
    assign timeout = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        cnt_d   = '0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        acc_d   = 1'b0;
        rv0_d   = 1'b0;
        rv1_d   = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        rd0_d   = '0;
        rd1_d   = '0;
        case (state_q)
            S_IDLE: begin
                if ((p0_req || p1_req) && !prog_mode) begin
                    state_d = S_ISSUE;
                    win_d   = pick;
                    last_d  = pick;
                    we_d    = pick ? p1_we    : p0_we;
                    addr_d  = pick ? p1_addr  : p0_addr;
                    wdata_d = pick ? p1_wdata : p0_wdata;
                    be_d    = pick ? p1_be    : p0_be;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                    acc_d   = 1'b1;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // mem_done takes priority over a timeout in the same cycle.
                if (mem_done || timeout) begin
                    state_d = S_RESP;
                    rv0_d   = ~win_q;
                    rv1_d   = win_q;
                    err0_d  = ~win_q & ~mem_done;
                    err1_d  = win_q & ~mem_done;
                    rd0_d   = (!win_q && mem_done) ? mem_d_out : '0;
                    rd1_d   = (win_q && mem_done) ? mem_d_out : '0;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            win_q   <= 1'b0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            acc_q   <= 1'b0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            acc_q   <= acc_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            busy_q  <= busy_d;
        end
    end

    assign p0_gnt            = gnt0_q;
    assign p1_gnt            = gnt1_q;
    assign p0_rvalid         = rv0_q;
    assign p1_rvalid         = rv1_q;
    assign p0_err            = err0_q;
    assign p1_err            = err1_q;
    assign p0_rdata          = rd0_q;
    assign p1_rdata          = rd1_q;
    assign memory_access     = acc_q;
    assign memory_is_writing = we_q;
    assign addr              = addr_q;
    assign d_in              = wdata_q;
    assign mem_be            = be_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter: a per-cycle vector table plus
// hand-written timeout, write, prog_mode and reset-mid-access sequences.
module tb_storage_arbiter;

    localparam int MEM_W = 32;
    localparam int BE_W  = MEM_W / 8;
    localparam int TO    = 8;

    localparam logic [7:0] G0 = 8'h80, G1 = 8'h40, AC = 8'h20, R0 = 8'h10;
    localparam logic [7:0] R1 = 8'h08, E0 = 8'h04, BS = 8'h01;

    logic             clk = 1'b0;
    logic             rst, prog_mode;
    logic             p0_req, p0_we, p1_req, p1_we;
    logic [31:0]      p0_addr, p1_addr;
    logic [MEM_W-1:0] p0_wdata, p1_wdata;
    logic [BE_W-1:0]  p0_be, p1_be;
    logic             p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [MEM_W-1:0] p0_rdata, p1_rdata;
    logic             memory_access, memory_is_writing;
    logic [31:0]      addr;
    logic [MEM_W-1:0] d_in, mem_d_out;
    logic [BE_W-1:0]  mem_be;
    logic             mem_done, busy;

    int n_chk  = 0;
    int n_pass = 0;

    storage_arbiter #(.MEM_W(MEM_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_be(p0_be),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_be(p1_be),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .memory_access(memory_access), .memory_is_writing(memory_is_writing),
        .addr(addr), .d_in(d_in), .mem_be(mem_be),
        .mem_d_out(mem_d_out), .mem_done(mem_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, req0, req1, done;
        logic [31:0] dout;
        logic [7:0]  ctrl;
        logic [31:0] rd0, rd1, ad;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic r, input logic q0, input logic q1, input logic dn,
                                input logic [31:0] dout, input logic [7:0] ctrl,
                                input logic [31:0] rd0, input logic [31:0] rd1,
                                input logic [31:0] ad);
        vec_t v;
        v.rst = r; v.req0 = q0; v.req1 = q1; v.done = dn; v.dout = dout;
        v.ctrl = ctrl; v.rd0 = rd0; v.rd1 = rd1; v.ad = ad;
        return v;
    endfunction

    function automatic logic [31:0] ctrl_now();
        return {24'h0, p0_gnt, p1_gnt, memory_access, p0_rvalid, p1_rvalid, p0_err, p1_err, busy};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; prog_mode = 1'b0; mem_done = 1'b0; mem_d_out = '0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 32'h0000_0100; p0_wdata = 32'h0; p0_be = 4'hF;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 32'h0000_0200; p1_wdata = 32'h0; p1_be = 4'hF;

        //            rst  q0   q1   done  dout          ctrl        rd0           rd1           addr
        vecs[0]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,        8'h00,      32'h0,        32'h0,        32'h0);
        vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0, 32'h0,        G0|AC|BS,   32'h0,        32'h0,        32'h100);
        vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0, 32'h0,        BS,         32'h0,        32'h0,        32'h100);
        vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0, 32'h0,        BS,         32'h0,        32'h0,        32'h100);
        vecs[4]  = mk(1'b0,1'b0,1'b0,1'b1, 32'hCAFEF00D, R0|BS,      32'hCAFEF00D, 32'h0,        32'h100);
        vecs[5]  = mk(1'b0,1'b0,1'b0,1'b0, 32'h0,        8'h00,      32'h0,        32'h0,        32'h100);
        vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0, 32'h0,        8'h00,      32'h0,        32'h0,        32'h0);
        vecs[7]  = mk(1'b0,1'b1,1'b1,1'b0, 32'h0,        G0|AC|BS,   32'h0,        32'h0,        32'h100);
        vecs[8]  = mk(1'b0,1'b1,1'b1,1'b0, 32'h0,        BS,         32'h0,        32'h0,        32'h100);
        vecs[9]  = mk(1'b0,1'b1,1'b1,1'b1, 32'h11110001, R0|BS,      32'h11110001, 32'h0,        32'h100);
        vecs[10] = mk(1'b0,1'b1,1'b1,1'b1, 32'h0000DEAD, 8'h00,      32'h0,        32'h0,        32'h100);
        vecs[11] = mk(1'b0,1'b1,1'b1,1'b0, 32'h0,        G1|AC|BS,   32'h0,        32'h0,        32'h200);
        vecs[12] = mk(1'b0,1'b1,1'b1,1'b1, 32'h0000BEEF, BS,         32'h0,        32'h0,        32'h200);
        vecs[13] = mk(1'b0,1'b1,1'b1,1'b1, 32'h22220002, R1|BS,      32'h0,        32'h22220002, 32'h200);
        vecs[14] = mk(1'b0,1'b1,1'b1,1'b0, 32'h0,        8'h00,      32'h0,        32'h0,        32'h200);
        vecs[15] = mk(1'b0,1'b1,1'b1,1'b0, 32'h0,        G0|AC|BS,   32'h0,        32'h0,        32'h100);
        vecs[16] = mk(1'b0,1'b0,1'b0,1'b0, 32'h0,        BS,         32'h0,        32'h0,        32'h100);
        vecs[17] = mk(1'b0,1'b0,1'b0,1'b1, 32'h33330003, R0|BS,      32'h33330003, 32'h0,        32'h100);
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b0, 32'h0,        8'h00,      32'h0,        32'h0,        32'h100);
        vecs[19] = mk(1'b0,1'b0,1'b0,1'b1, 32'h44444444, 8'h00,      32'h0,        32'h0,        32'h100);

        for (int i = 0; i < 20; i++) begin
            rst = vecs[i].rst; p0_req = vecs[i].req0; p1_req = vecs[i].req1;
            mem_done = vecs[i].done; mem_d_out = vecs[i].dout;
            tick();
            chk($sformatf("row%0d ctrl", i), ctrl_now(), {24'h0, vecs[i].ctrl});
            chk($sformatf("row%0d p0_rdata", i), p0_rdata, vecs[i].rd0);
            chk($sformatf("row%0d p1_rdata", i), p1_rdata, vecs[i].rd1);
            chk($sformatf("row%0d addr", i), addr, vecs[i].ad);
        end
        rst = 1'b0; p0_req = 1'b0; p1_req = 1'b0; mem_done = 1'b0;

        // Timeout: no mem_done, error response after TO wait cycles.
        p0_req = 1'b1;
        tick();
        chk("to gnt", ctrl_now(), {24'h0, G0 | AC | BS});
        p0_req = 1'b0;
        for (int c = 2; c < 2 + TO; c++) begin
            tick();
            chk($sformatf("to wait c%0d", c), ctrl_now(), {24'h0, BS});
        end
        tick();
        chk("to resp ctrl", ctrl_now(), {24'h0, R0 | E0 | BS});
        chk("to resp rdata", p0_rdata, 32'h0);
        mem_done = 1'b1; mem_d_out = 32'hFFFF_FFFF;
        tick();
        chk("to late done 1", ctrl_now(), 32'h0);
        tick();
        chk("to late done 2", ctrl_now(), 32'h0);
        mem_done = 1'b0;

        // Write path on port 1.
        p1_we = 1'b1; p1_addr = 32'h0000_2000; p1_wdata = 32'h1234_5678; p1_be = 4'b0011;
        p1_req = 1'b1;
        tick();
        chk("wr gnt", ctrl_now(), {24'h0, G1 | AC | BS});
        chk("wr addr", addr, 32'h2000);
        p1_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("wr we s%0d", c), {31'h0, memory_is_writing}, 32'h1);
            chk($sformatf("wr d_in s%0d", c), d_in, 32'h1234_5678);
            chk($sformatf("wr be s%0d", c), {28'h0, mem_be}, 32'h3);
            if (c < 2) tick();
        end
        mem_done = 1'b1; mem_d_out = 32'h5555_AAAA;
        tick();
        chk("wr resp", ctrl_now(), {24'h0, R1 | BS});
        mem_done = 1'b0;
        tick();
        chk("wr idle", ctrl_now(), 32'h0);
        p1_we = 1'b0;

        // prog_mode blocks grants but not an access already in flight.
        prog_mode = 1'b1; p0_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("prog hold c%0d", c), ctrl_now(), 32'h0);
        end
        prog_mode = 1'b0;
        tick();
        chk("prog release gnt", ctrl_now(), {24'h0, G0 | AC | BS});
        p0_req = 1'b0;
        tick();
        prog_mode = 1'b1;
        tick();
        chk("prog mid wait", ctrl_now(), {24'h0, BS});
        mem_done = 1'b1; mem_d_out = 32'h0BAD_CAFE;
        tick();
        chk("prog mid resp", ctrl_now(), {24'h0, R0 | BS});
        chk("prog mid rdata", p0_rdata, 32'h0BAD_CAFE);
        mem_done = 1'b0;
        tick();
        chk("prog mid idle", ctrl_now(), 32'h0);
        prog_mode = 1'b0;

        // Reset during WAIT after port 0 won, then a tie must go to port 0.
        p0_we = 1'b1; p0_wdata = 32'hA5A5_A5A5; p0_be = 4'hF; p0_req = 1'b1;
        tick();
        chk("rst gnt", ctrl_now(), {24'h0, G0 | AC | BS});
        p0_req = 1'b0;
        tick();
        chk("rst pre we", {31'h0, memory_is_writing}, 32'h1);
        rst = 1'b1;
        tick();
        chk("rst ctrl", ctrl_now(), 32'h0);
        chk("rst addr", addr, 32'h0);
        chk("rst d_in", d_in, 32'h0);
        chk("rst be", {28'h0, mem_be}, 32'h0);
        chk("rst we", {31'h0, memory_is_writing}, 32'h0);
        rst = 1'b0; mem_done = 1'b1; mem_d_out = 32'h7777_7777;
        tick();
        chk("rst no resp 1", ctrl_now(), 32'h0);
        mem_done = 1'b0;
        tick();
        chk("rst no resp 2", ctrl_now(), 32'h0);
        p0_we = 1'b0; p0_req = 1'b1; p1_req = 1'b1;
        tick();
        chk("rst tie gnt", ctrl_now(), {24'h0, G0 | AC | BS});
        p0_req = 1'b0; p1_req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
